// File: rtl/alu_pipe_if.sv
// Issue-side and result-side handshakes of alu_pipe, bundled as one interface.
// The slave modport is the ALU's view; the master modport is the surrounding datapath's view.
interface alu_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAGW  = 4
);
   logic             valid_i;
   logic             ready_o;
   logic [3:0]       aluop;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [TAGW-1:0]  tag_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] f;
   logic             zero_o;
   logic             carry_o;
   logic             illegal_o;
   logic [TAGW-1:0]  tag_o;

   modport slave (
      input  valid_i, aluop, a, b, tag_i, ready_i,
      output ready_o, valid_o, f, zero_o, carry_o, illegal_o, tag_o
   );

   modport master (
      output valid_i, aluop, a, b, tag_i, ready_i,
      input  ready_o, valid_o, f, zero_o, carry_o, illegal_o, tag_o
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides: S1 holds operands,
// S2 holds the result and flags; a stage advances only when the one after it can take data.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int TAGW  = 4
) (
   input  logic       clk,
   input  logic       rst,
   alu_pipe_if.slave  io_bus
);
   localparam int N = $clog2(WIDTH);

   typedef enum logic [3:0] {
      OP_AND  = 4'd0,
      OP_OR   = 4'd1,
      OP_NOT  = 4'd2,
      OP_ADD  = 4'd3,
      OP_SUB  = 4'd4,
      OP_SHL  = 4'd5,
      OP_SHR  = 4'd6,
      OP_SRA  = 4'd7,
      OP_XOR  = 4'd8,
      OP_SLT  = 4'd9,
      OP_SLTU = 4'd10
   } op_e;

   logic             w_adv1;
   logic             w_adv2;
   logic             r_s1_v;
   logic [3:0]       r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [TAGW-1:0]  r_s1_tag;
   logic             r_s2_v;
   logic [WIDTH-1:0] r_s2_f;
   logic             r_s2_zero;
   logic             r_s2_carry;
   logic             r_s2_illegal;
   logic [TAGW-1:0]  r_s2_tag;
   logic [N-1:0]     w_sh;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_f;
   logic             w_carry;
   logic             w_illegal;

   // ready_i reaches ready_o combinationally so a full pipe still streams at one op per cycle.
   assign w_adv2         = !r_s2_v || io_bus.ready_i;
   assign w_adv1         = !r_s1_v || w_adv2;
   assign io_bus.ready_o = w_adv1;

   assign w_sh  = r_s1_b[N-1:0];
   assign w_sum = {1'b0, r_s1_a} + {1'b0, r_s1_b};

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_f       = '0;
      w_carry   = 1'b0;
      w_illegal = 1'b0;
      case (r_s1_op)
         OP_AND:  w_f = r_s1_a & r_s1_b;
         OP_OR:   w_f = r_s1_a | r_s1_b;
         OP_NOT:  w_f = ~r_s1_a;
         OP_ADD:  {w_carry, w_f} = w_sum;
         OP_SUB: begin
            w_f     = r_s1_a - r_s1_b;
            w_carry = (r_s1_a >= r_s1_b);
         end
         OP_SHL:  w_f = r_s1_a << w_sh;
         OP_SHR:  w_f = r_s1_a >> w_sh;
         OP_SRA:  w_f = $signed(r_s1_a) >>> w_sh;
         OP_XOR:  w_f = r_s1_a ^ r_s1_b;
         OP_SLT:  w_f = {{(WIDTH-1){1'b0}}, $signed(r_s1_a) < $signed(r_s1_b)};
         OP_SLTU: w_f = {{(WIDTH-1){1'b0}}, r_s1_a < r_s1_b};
         default: w_illegal = 1'b1;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so both stages see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v   <= 1'b0;
         r_s1_op  <= '0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s1_tag <= '0;
      end else if (w_adv1) begin
         r_s1_v <= io_bus.valid_i;
         if (io_bus.valid_i) begin
            r_s1_op  <= io_bus.aluop;
            r_s1_a   <= io_bus.a;
            r_s1_b   <= io_bus.b;
            r_s1_tag <= io_bus.tag_i;
         end
      end
   end

   // Result registers only load with a real op, so they hold steady under backpressure and bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_v       <= 1'b0;
         r_s2_f       <= '0;
         r_s2_zero    <= 1'b0;
         r_s2_carry   <= 1'b0;
         r_s2_illegal <= 1'b0;
         r_s2_tag     <= '0;
      end else if (w_adv2) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_f       <= w_f;
            r_s2_zero    <= (w_f == '0);
            r_s2_carry   <= w_carry;
            r_s2_illegal <= w_illegal;
            r_s2_tag     <= r_s1_tag;
         end
      end
   end

   assign io_bus.valid_o   = r_s2_v;
   assign io_bus.f         = r_s2_f;
   assign io_bus.zero_o    = r_s2_zero;
   assign io_bus.carry_o   = r_s2_carry;
   assign io_bus.illegal_o = r_s2_illegal;
   assign io_bus.tag_o     = r_s2_tag;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a scoreboard fed by an arithmetic model checks every result,
// and literal expectations pin both the model and the DUT on the listed scenarios.
module tb_alu_pipe;
   localparam int W  = 32;
   localparam int TW = 4;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_NOT  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_XOR  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;

   typedef struct packed {
      logic [63:0]   f;
      logic          z;
      logic          c;
      logic          il;
      logic [TW-1:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(W), .TAGW(TW)) bus ();
   alu_pipe_if #(.WIDTH(8), .TAGW(TW)) bus8 ();

   alu_pipe #(.WIDTH(W), .TAGW(TW)) dut (.clk(clk), .rst(rst), .io_bus(bus));
   alu_pipe #(.WIDTH(8), .TAGW(TW)) dut8 (.clk(clk), .rst(rst), .io_bus(bus8));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Result of one op on a w-bit datapath, from the arithmetic definitions alone.
   function automatic exp_t model(input int w, input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [TW-1:0] tag);
      exp_t        r;
      logic [63:0] mask;
      logic [63:0] sh;
      logic [63:0] s;
      longint      sa;
      longint      sb_s;
      mask = (64'd1 << w) - 64'd1;
      sh   = b % 64'(w);
      sa   = a[w-1] ? longint'(a | ~mask) : longint'(a);
      sb_s = b[w-1] ? longint'(b | ~mask) : longint'(b);
      r    = '0;
      r.tag = tag;
      case (op)
         OP_AND:  r.f = a & b;
         OP_OR:   r.f = a | b;
         OP_NOT:  r.f = ~a & mask;
         OP_ADD: begin
            s   = a + b;
            r.f = s & mask;
            r.c = s[w];
         end
         OP_SUB: begin
            r.f = (a - b) & mask;
            r.c = (a >= b);
         end
         OP_SHL:  r.f = (a << sh) & mask;
         OP_SHR:  r.f = a >> sh;
         OP_SRA:  r.f = 64'(sa >>> sh) & mask;
         OP_XOR:  r.f = a ^ b;
         OP_SLT:  r.f = (sa < sb_s) ? 64'd1 : 64'd0;
         OP_SLTU: r.f = (a < b) ? 64'd1 : 64'd0;
         default: r.il = 1'b1;
      endcase
      r.z = (r.f == 64'd0);
      return r;
   endfunction

   // Compare process: transfers are decided at the coming rising edge, so look at the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         check("ready_o", bus.ready_o, (sb.size() < 2) || bus.ready_i);
         if (bus.valid_o) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL out_unexpected: valid_o=1 tag=%0d, expected no result", bus.tag_o);
            end else begin
               check("sb_f",       bus.f,         sb[0].f);
               check("sb_zero",    bus.zero_o,    sb[0].z);
               check("sb_carry",   bus.carry_o,   sb[0].c);
               check("sb_illegal", bus.illegal_o, sb[0].il);
               check("sb_tag",     bus.tag_o,     sb[0].tag);
               if (bus.ready_i) void'(sb.pop_front());
            end
         end
         if (bus.valid_i && bus.ready_o)
            sb.push_back(model(W, bus.aluop, 64'(bus.a), 64'(bus.b), bus.tag_i));
      end
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tag);
      bus.valid_i = 1'b1;
      bus.aluop   = op;
      bus.a       = a;
      bus.b       = b;
      bus.tag_i   = tag;
   endtask

   task automatic idle();
      bus.valid_i = 1'b0;
   endtask

   // Present an op and wait (bounded) until it is accepted; returns just after the accepting edge.
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] tag);
      int k;
      k = 0;
      drive(op, a, b, tag);
      @(negedge clk);
      while (!bus.ready_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!bus.ready_o) begin
         total++;
         bad++;
         $display("FAIL send_timeout: ready_o stayed 0 for tag %0d, expected acceptance", tag);
      end
      @(posedge clk);
      #1;
   endtask

   // Single op through an empty pipe with ready_i=1; result checked one edge after acceptance.
   task automatic run1(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] tag, input logic [31:0] ef,
                       input logic ez, input logic ec, input logic eil);
      drive(op, a, b, tag);
      @(posedge clk);
      #1;
      idle();
      @(posedge clk);
      #1;
      check({nm, "_valid"},   bus.valid_o,   1);
      check({nm, "_f"},       bus.f,         ef);
      check({nm, "_zero"},    bus.zero_o,    ez);
      check({nm, "_carry"},   bus.carry_o,   ec);
      check({nm, "_illegal"}, bus.illegal_o, eil);
      check({nm, "_tag"},     bus.tag_o,     tag);
      @(posedge clk);
      #1;
   endtask

   task automatic run8(input string nm, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] ef, input logic ec);
      bus8.valid_i = 1'b1;
      bus8.aluop   = op;
      bus8.a       = a;
      bus8.b       = b;
      bus8.tag_i   = 4'd9;
      @(posedge clk);
      #1;
      bus8.valid_i = 1'b0;
      @(posedge clk);
      #1;
      check({nm, "_valid"}, bus8.valid_o, 1);
      check({nm, "_f"},     bus8.f,       ef);
      check({nm, "_carry"}, bus8.carry_o, ec);
      check({nm, "_tag"},   bus8.tag_o,   4'd9);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst          = 1'b1;
      bus.valid_i  = 1'b0;
      bus.aluop    = '0;
      bus.a        = '0;
      bus.b        = '0;
      bus.tag_i    = '0;
      bus.ready_i  = 1'b1;
      bus8.valid_i = 1'b0;
      bus8.aluop   = '0;
      bus8.a       = '0;
      bus8.b       = '0;
      bus8.tag_i   = '0;
      bus8.ready_i = 1'b1;

      // Pin the model against hand-computed values.
      check("model_add",   model(32, OP_ADD, 5, 7, 0).f, 12);
      check("model_sub",   model(32, OP_SUB, 3, 5, 0).f, 64'hFFFF_FFFE);
      check("model_sra",   model(32, OP_SRA, 64'h8000_0000, 4, 0).f, 64'hF800_0000);
      check("model_slt",   model(32, OP_SLT, 64'hFFFF_FFFF, 1, 0).f, 1);
      check("model_add8c", model(8, OP_ADD, 8'hF0, 8'h20, 0).c, 1);
      check("model_sra8",  model(8, OP_SRA, 8'h80, 8'h0B, 0).f, 64'hF0);

      repeat (2) @(negedge clk);
      check("rst_valid_o", bus.valid_o,   0);
      check("rst_f",       bus.f,         0);
      check("rst_zero",    bus.zero_o,    0);
      check("rst_carry",   bus.carry_o,   0);
      check("rst_illegal", bus.illegal_o, 0);
      check("rst_tag",     bus.tag_o,     0);
      check("rst8_valid",  bus8.valid_o,  0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", bus.ready_o, 1);
      @(posedge clk);
      #1;

      // Back-to-back stream with ready_i=1.
      drive(OP_ADD, 5, 7, 4'd1);
      @(posedge clk);
      #1;
      drive(OP_SUB, 3, 5, 4'd2);
      check("str_lat_valid", bus.valid_o, 0);
      @(posedge clk);
      #1;
      drive(OP_SRA, 32'h8000_0000, 4, 4'd3);
      check("str1_valid", bus.valid_o, 1);
      check("str1_f",     bus.f,       12);
      check("str1_carry", bus.carry_o, 0);
      check("str1_tag",   bus.tag_o,   1);
      @(posedge clk);
      #1;
      idle();
      check("str2_valid", bus.valid_o, 1);
      check("str2_f",     bus.f,       32'hFFFF_FFFE);
      check("str2_carry", bus.carry_o, 0);
      check("str2_tag",   bus.tag_o,   2);
      @(posedge clk);
      #1;
      check("str3_valid", bus.valid_o, 1);
      check("str3_f",     bus.f,       32'hF800_0000);
      check("str3_tag",   bus.tag_o,   3);
      @(posedge clk);
      #1;
      check("str_end_valid", bus.valid_o, 0);

      // Flags, compares, remaining ops, shift masking and illegal opcode.
      run1("add_wrap", OP_ADD,  32'hFFFF_FFFF, 1, 4'd4, 0, 1, 1, 0);
      run1("sub_eq",   OP_SUB,  9, 9, 4'd5, 0, 1, 1, 0);
      run1("slt",      OP_SLT,  32'hFFFF_FFFF, 1, 4'd6, 1, 0, 0, 0);
      run1("sltu",     OP_SLTU, 32'hFFFF_FFFF, 1, 4'd7, 0, 1, 0, 0);
      run1("slt_pos",  OP_SLT,  1, 32'hFFFF_FFFF, 4'd8, 0, 1, 0, 0);
      run1("sltu_pos", OP_SLTU, 1, 32'hFFFF_FFFF, 4'd9, 1, 0, 0, 0);
      run1("and",      OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 4'd10, 32'h0F00_0F00, 0, 0, 0);
      run1("or",       OP_OR,   32'hFF00_FF00, 32'h0FF0_0FF0, 4'd11, 32'hFFF0_FFF0, 0, 0, 0);
      run1("xor",      OP_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0, 4'd12, 32'hF0F0_F0F0, 0, 0, 0);
      run1("not",      OP_NOT,  32'h0000_FFFF, 0, 4'd13, 32'hFFFF_0000, 0, 0, 0);
      run1("shl_mask", OP_SHL,  1, 32'h23, 4'd14, 8, 0, 0, 0);
      run1("shr_mask", OP_SHR,  32'h8000_0000, 32'h3F, 4'd15, 1, 0, 0, 0);
      run1("illegal",  4'd13,   32'h1234_5678, 32'h9, 4'd0, 0, 1, 0, 1);

      // Backpressure: fill both stages, hold ready_i low, then release.
      bus.ready_i = 1'b0;
      send(OP_ADD, 100, 200, 4'd1);
      send(OP_SUB, 50, 8, 4'd2);
      drive(OP_XOR, 32'hAAAA_0000, 32'h0000_5555, 4'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_ready", bus.ready_o, 0);
         check("bp_valid", bus.valid_o, 1);
         check("bp_f",     bus.f,       300);
         check("bp_tag",   bus.tag_o,   1);
      end
      @(posedge clk);
      #1;
      bus.ready_i = 1'b1;
      send(OP_XOR, 32'hAAAA_0000, 32'h0000_5555, 4'd3);
      send(OP_SHL, 32'h0000_0003, 32'h0000_0041, 4'd4);
      idle();
      k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("bp_drain_empty", sb.size(), 0);
      check("bp_drain_valid", bus.valid_o, 0);

      // 8-bit instance.
      run8("w8_add", OP_ADD, 8'hF0, 8'h20, 8'h10, 1);
      run8("w8_sra", OP_SRA, 8'h80, 8'h0B, 8'hF0, 0);

      // Asynchronous reset with two ops in flight.
      drive(OP_ADD, 1, 2, 4'd5);
      @(posedge clk);
      #1;
      drive(OP_OR, 32'hF0, 32'h0F, 4'd6);
      @(posedge clk);
      #1;
      idle();
      check("mid_valid_before", bus.valid_o, 1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.valid_o, 0);
      check("mid_rst_f",     bus.f,       0);
      check("mid_rst_tag",   bus.tag_o,   0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("mid_ready_after", bus.ready_o, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mid_no_stale", bus.valid_o, 0);
      end

      check("final_sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
